button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
//
// PURPOSE
//  Input-side counterpart to the LED blinker: conditions noisy external pushbuttons/switches for internal logic.
//  Each input is synchronised and then sampled on a shared slow tick. Its debounced level changes only after SAMPLES
//  consecutive agreeing samples. A one-cycle rise/fall pulse marks every change.
//  Sits between board I/O pins and control/status logic. test_mode shortens the tick period for simulation.
//
// PARAMETERS
//  BUTTONS           2       number of independent input channels
//  SAMPLES           4       consecutive agreeing samples required to change level (>=2)
//  TICK_PERIOD       125000  clk cycles per sample tick in normal mode (1 ms at 125 MHz)
//  TEST_TICK_PERIOD  4       clk cycles per sample tick when test_mode=1 (>=2)
//  INVERT            0       BUTTONS-bit mask; a set bit means the raw input is active-low
//
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous active-low reset
//  buttons    in   BUTTONS  raw asynchronous pin inputs
//  level      out  BUTTONS  debounced active-high level, registered
//  rise       out  BUTTONS  one-cycle pulse when level goes 0->1
//  fall       out  BUTTONS  one-cycle pulse when level goes 1->0
//  test_mode  in   1        select TEST_TICK_PERIOD at next timer reload
//
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - level, rise, fall, synchronisers, agree counters and tick timer all cleared to 0.
//   - Takes effect immediately, including mid-count; an in-progress count is discarded.
//  Synchroniser
//   - Per channel 2-FF chain on (buttons ^ INVERT).
//   - The synced value lags the pin by 2 clk edges.
//  Tick timer
//   - Down-counter; tick=1 during the cycle the counter is 0.
//   - When 0, reload with (test_mode ? TEST_TICK_PERIOD : TICK_PERIOD) - 1; otherwise decrement.
//   - First tick occurs on the first cycle after reset release.
//   - A change of test_mode takes effect at the next reload only.
//   - Width is $clog2(TICK_PERIOD).
//  Per-channel state: level bit s, agree counter c, width $clog2(SAMPLES).
//   - No tick: s and c hold.
//   - Tick, synced == s: c <= 0.
//   - Tick, synced != s, c < SAMPLES-1: c <= c+1.
//   - Tick, synced != s, c == SAMPLES-1: s <= synced, c <= 0, and the matching rise/fall asserts on the same edge.
//  Pulses
//   - rise/fall are high for exactly one clk and deassert on the next edge.
//   - rise and fall are never both high for the same channel.
//   - Minimum spacing between two pulses on one channel is SAMPLES ticks.
//  Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
//  Latency: a clean step on a pin changes level after 2 cycles + SAMPLES ticks (+ up to one tick period of alignment).
//  Glitch rejection: any disagreement shorter than SAMPLES consecutive ticks leaves level unchanged.
//
// TESTING (test_mode=1, defaults, INVERT=0)
//  1. Reset release, buttons=0 for 50 cycles
//     -> level=0, and rise/fall never asserted.
//  2. buttons[0] 0->1 at cycle t and held
//     -> level[0]=1 first seen between t+14 and t+18.
//     -> rise[0] high exactly 1 cycle; level[1] unchanged.
//  3. buttons[0]=1 for 10 cycles then back to 0 (3 ticks max)
//     -> level[0] stays 0, and no pulses.
//  4. Bounce: toggle buttons[1] every 3 cycles for 40 cycles, then hold at 1
//     -> exactly one rise[1], issued only after the hold.
//  5. Count at 3 agreeing samples, then assert rst_n=0 asynchronously mid-cycle
//     -> all outputs 0 immediately.
//     -> After release, a full 4 more ticks are needed to raise level.
//  6. test_mode=0, single step on buttons[0]
//     -> level rises after 4*125000 +/- 125000 cycles.
//     -> Both channels stepped on the same cycle give rise pulses on the same cycle.
//     -> INVERT=2'b10 with buttons[1] held 0 gives level[1]=1.

Source files
------------

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: pin-side inputs and debounced outputs of the button debouncer
interface button_debouncer_if #(
    parameter int BUTTONS = 2
);
    logic [BUTTONS-1:0] buttons;
    logic               test_mode;
    logic [BUTTONS-1:0] level;
    logic [BUTTONS-1:0] rise;
    logic [BUTTONS-1:0] fall;
    modport master(output buttons, test_mode, input level, rise, fall);
    modport slave(input buttons, test_mode, output level, rise, fall);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise raw pins, sample on a shared tick, change level after SAMPLES agreeing ticks
module button_debouncer #(
    parameter int                 BUTTONS          = 2,
    parameter int                 SAMPLES          = 4,
    parameter int                 TICK_PERIOD      = 125000,
    parameter int                 TEST_TICK_PERIOD = 4,
    parameter logic [BUTTONS-1:0] INVERT           = '0
) (
    input logic                clk,
    input logic                rst_n,
    button_debouncer_if.slave  io
);
    localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int CW = $clog2(SAMPLES);
    logic [TW-1:0]      timer_q, timer_d;
    logic [BUTTONS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [BUTTONS-1:0] level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    logic [CW-1:0]      cnt_q [BUTTONS];
    logic [CW-1:0]      cnt_d [BUTTONS];
    logic [BUTTONS-1:0] diff, done;
    logic               tick;
    assign io.level = level_q;
    assign io.rise  = rise_q;
    assign io.fall  = fall_q;
    always_comb begin
        tick    = timer_q == '0;
        timer_d = tick ? (io.test_mode ? TW'(TEST_TICK_PERIOD - 1) : TW'(TICK_PERIOD - 1))
                       : timer_q - TW'(1);
        sync1_d = io.buttons ^ INVERT;
        sync2_d = sync1_q;
        diff    = sync2_q ^ level_q;
        for (int i = 0; i < BUTTONS; i++) begin
            done[i]  = tick && diff[i] && (cnt_q[i] == CW'(SAMPLES - 1));
            cnt_d[i] = !tick ? cnt_q[i] : (diff[i] && !done[i]) ? cnt_q[i] + CW'(1) : '0;
        end
        level_d = level_q ^ done;
        rise_d  = done & sync2_q;
        fall_d  = done & ~sync2_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= '0;
        end else begin
            timer_q <= timer_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed stimulus with a pulse scoreboard for two debouncer instances
module tb_button_debouncer;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   compared = 0;
    int   failed = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debouncer_if #(.BUTTONS(2)) ifa ();
    button_debouncer_if #(.BUTTONS(2)) ifb ();

    button_debouncer dut_a (.clk(clk), .rst_n(rst_a), .io(ifa));
    // short normal-mode period keeps the test_mode=0 run brief
    button_debouncer #(.TICK_PERIOD(20), .INVERT(2'b10)) dut_b (.clk(clk), .rst_n(rst_b), .io(ifb));

    typedef struct {
        bit         d;
        logic [1:0] r;
        logic [1:0] f;
        int         lo;
        int         hi;
    } exp_t;
    exp_t q[$];

    task automatic push(input bit d, input logic [1:0] r, input logic [1:0] f, input int lo, input int hi);
        exp_t e;
        e.d = d; e.r = r; e.f = f; e.lo = lo; e.hi = hi;
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [1:0] act, input logic [1:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b required %b (cyc %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        logic [1:0] r, f;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            r = d ? ifb.rise : ifa.rise;
            f = d ? ifb.fall : ifa.fall;
            if ((r | f) != 2'b00) begin
                compared++;
                if (q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_pulse dut%0d cyc=%0d: got rise=%b fall=%b required none", d, cyc, r, f);
                end else begin
                    e = q.pop_front();
                    if (e.d != d || e.r !== r || e.f !== f || cyc < e.lo || cyc > e.hi) begin
                        failed++;
                        $display("FAIL pulse: got dut%0d rise=%b fall=%b cyc=%0d required dut%0d rise=%b fall=%b cyc %0d..%0d",
                                 d, r, f, cyc, e.d, e.r, e.f, e.lo, e.hi);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.buttons = 2'b00;
        ifa.test_mode = 1'b1;
        ifb.buttons = 2'b00;
        ifb.test_mode = 1'b0;
        wait_cyc(3);
        chk("reset_level", ifa.level, 2'b00);
        chk("reset_pulses", ifa.rise | ifa.fall, 2'b00);
        rst_a = 1'b1;
        wait_cyc(50);
        chk("idle_level", ifa.level, 2'b00);
        // clean step up and back down on channel 0
        ifa.buttons = 2'b01;
        push(0, 2'b01, 2'b00, cyc + 14, cyc + 18);
        wait_cyc(25);
        chk("step_up_level", ifa.level, 2'b01);
        ifa.buttons = 2'b00;
        push(0, 2'b00, 2'b01, cyc + 14, cyc + 18);
        wait_cyc(25);
        chk("step_down_level", ifa.level, 2'b00);
        // 10-cycle glitch spans at most 3 ticks
        ifa.buttons = 2'b01;
        wait_cyc(10);
        ifa.buttons = 2'b00;
        wait_cyc(30);
        chk("glitch_level", ifa.level, 2'b00);
        // bounce on channel 1, then hold high
        for (int s = 0; s < 14; s++) begin
            ifa.buttons[1] = (s % 2 == 0);
            wait_cyc(3);
        end
        chk("bounce_level", ifa.level, 2'b00);
        ifa.buttons[1] = 1'b1;
        push(0, 2'b10, 2'b00, cyc + 1, cyc + 18);
        wait_cyc(25);
        chk("bounce_hold_level", ifa.level, 2'b10);
        // three agreeing ticks on channel 0, then async reset
        ifa.buttons[0] = 1'b1;
        wait_cyc(14);
        chk("pre_reset_level", ifa.level, 2'b10);
        rst_a = 1'b0;
        #1;
        chk("async_reset_level", ifa.level, 2'b00);
        chk("async_reset_pulses", ifa.rise | ifa.fall, 2'b00);
        wait_cyc(3);
        rst_a = 1'b1;
        push(0, 2'b11, 2'b00, cyc + 17, cyc + 17);
        wait_cyc(16);
        chk("post_reset_hold", ifa.level, 2'b00);
        wait_cyc(9);
        chk("post_reset_level", ifa.level, 2'b11);
        // normal tick period and inverted channel 1
        rst_b = 1'b1;
        push(1, 2'b10, 2'b00, cyc + 60, cyc + 100);
        wait_cyc(110);
        chk("invert_level", ifb.level, 2'b10);
        t = cyc;
        ifb.buttons = 2'b11;
        push(1, 2'b01, 2'b10, t + 60, t + 100);
        wait_cyc(110);
        chk("simultaneous_level", ifb.level, 2'b01);
        wait_cyc(5);
        compared++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL missing_pulses: got %0d outstanding required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
